// File: rtl/qam_pkg.sv
// qam_pkg: shared widths, carrier quarter-turn constant and helper functions
// for the QAM upconverter slice.
package qam_pkg;

    localparam int D_W     = 16;
    localparam int LUT_AW  = 8;
    localparam int LUT_W   = 16;
    localparam int OUT_W   = 18;
    localparam int PHASE_W = 32;

    localparam logic [PHASE_W-1:0] QUARTER = {2'b01, {(PHASE_W-2){1'b0}}};

    function automatic logic signed [63:0] sat_sym(
        input logic signed [63:0] value,
        input int                 width
    );
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (width - 1)) - 64'sd1;
        if (value > lim)  return lim;
        if (value < -lim) return -lim;
        return value;
    endfunction

    // Taylor series keeps ROM generation free of math-library calls.
    function automatic real sin_r(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n < 10; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic int rom_entry(input int k);
        real amp;
        real x;
        amp = real'((1 << (LUT_W - 1)) - 1);
        x   = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5)
              / real'(1 << LUT_AW);
        return $rtoi(amp * sin_r(x) + 0.5);
    endfunction

endpackage

// File: rtl/qam_quarter_sine_rom.sv
// qam_quarter_sine_rom: quarter-wave sine table with two registered
// read ports (sin and cos) sharing one set of contents.
module qam_quarter_sine_rom
    import qam_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [LUT_AW-1:0] sin_addr,
    input  logic [LUT_AW-1:0] cos_addr,
    output logic [LUT_W-1:0]  sin_data,
    output logic [LUT_W-1:0]  cos_data
);

    logic [LUT_W-1:0] rom [2**LUT_AW];

    for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
        assign rom[k] = LUT_W'(rom_entry(k));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sin_data <= '0;
            cos_data <= '0;
        end else if (enable) begin
            sin_data <= rom[sin_addr];
            cos_data <= rom[cos_addr];
        end
    end

endmodule

// File: rtl/qam_upconverter.sv
// qam_upconverter: NCO-driven quadrature mixer, I*cos - Q*sin, with
// input slice/saturate and rounded, saturated passband output.
module qam_upconverter
    import qam_pkg::*;
#(
    parameter int                 IN_W         = 64,
    parameter int                 IN_SLICE_LSB = 40,
    parameter logic [PHASE_W-1:0] FCW_RESET    = 32'h0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic [PHASE_W-1:0]      fcw,
    input  logic                    fcw_load,
    input  logic signed [IN_W-1:0]  in_i,
    input  logic signed [IN_W-1:0]  in_q,
    output logic signed [OUT_W-1:0] out_rf,
    output logic                    out_valid
);

    localparam int PW  = LUT_AW + 2;
    localparam int P_W = D_W + LUT_W;
    localparam int R   = P_W + 1 - OUT_W;

    logic [PHASE_W-1:0]      phase;
    logic [PHASE_W-1:0]      fcw_reg;
    logic [PW-1:0]           sin_p;
    logic [PW-1:0]           cos_p;
    logic [LUT_AW-1:0]       sin_a;
    logic [LUT_AW-1:0]       cos_a;
    logic [LUT_AW-1:0]       sin_a1;
    logic [LUT_AW-1:0]       cos_a1;
    logic                    sin_neg1;
    logic                    cos_neg1;
    logic                    sin_neg2;
    logic                    cos_neg2;
    logic signed [D_W-1:0]   slice_i;
    logic signed [D_W-1:0]   slice_q;
    logic signed [D_W-1:0]   i1;
    logic signed [D_W-1:0]   q1;
    logic signed [D_W-1:0]   i2;
    logic signed [D_W-1:0]   q2;
    logic [LUT_W-1:0]        sin_mag;
    logic [LUT_W-1:0]        cos_mag;
    logic signed [LUT_W-1:0] sin_v;
    logic signed [LUT_W-1:0] cos_v;
    logic signed [P_W-1:0]   prod_i;
    logic signed [P_W-1:0]   prod_q;
    logic signed [P_W:0]     diff;
    logic signed [P_W:0]     rnd;
    logic signed [P_W:0]     shifted;
    logic signed [OUT_W-1:0] out_next;
    logic [2:0]              fill;
    logic [2:0]              fill_next;

    // Shifting the whole word keeps bits above the slice for the clip test.
    assign slice_i = D_W'(sat_sym(64'(in_i >>> IN_SLICE_LSB), D_W));
    assign slice_q = D_W'(sat_sym(64'(in_q >>> IN_SLICE_LSB), D_W));

    assign sin_p = phase[PHASE_W-1 -: PW];
    assign cos_p = PW'((phase + QUARTER) >> (PHASE_W - PW));

    // Odd quadrants read the table mirrored, upper half is negated.
    assign sin_a = sin_p[PW-2] ? ~sin_p[LUT_AW-1:0] : sin_p[LUT_AW-1:0];
    assign cos_a = cos_p[PW-2] ? ~cos_p[LUT_AW-1:0] : cos_p[LUT_AW-1:0];

    assign sin_v = sin_neg2 ? -signed'(sin_mag) : signed'(sin_mag);
    assign cos_v = cos_neg2 ? -signed'(cos_mag) : signed'(cos_mag);

    assign diff     = (P_W+1)'(prod_i) - (P_W+1)'(prod_q);
    assign rnd      = diff + (P_W+1)'(1 << (R - 1));
    assign shifted  = rnd >>> R;
    assign out_next = OUT_W'(sat_sym(64'(shifted), OUT_W));

    assign fill_next = (fill == 3'd4) ? fill : fill + 3'd1;

    qam_quarter_sine_rom u_rom (
        .clk      (clk),
        .reset    (reset),
        .enable   (clk_enable),
        .sin_addr (sin_a1),
        .cos_addr (cos_a1),
        .sin_data (sin_mag),
        .cos_data (cos_mag)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= '0;
            fcw_reg   <= FCW_RESET;
            i1        <= '0;
            q1        <= '0;
            sin_a1    <= '0;
            cos_a1    <= '0;
            sin_neg1  <= 1'b0;
            cos_neg1  <= 1'b0;
            i2        <= '0;
            q2        <= '0;
            sin_neg2  <= 1'b0;
            cos_neg2  <= 1'b0;
            prod_i    <= '0;
            prod_q    <= '0;
            out_rf    <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= clk_enable && (fill_next == 3'd4);
            if (clk_enable) begin
                phase <= phase + fcw_reg;
                if (fcw_load) begin
                    fcw_reg <= fcw;
                end
                i1       <= slice_i;
                q1       <= slice_q;
                sin_a1   <= sin_a;
                cos_a1   <= cos_a;
                sin_neg1 <= sin_p[PW-1];
                cos_neg1 <= cos_p[PW-1];
                i2       <= i1;
                q2       <= q1;
                sin_neg2 <= sin_neg1;
                cos_neg2 <= cos_neg1;
                prod_i   <= P_W'(i2) * P_W'(cos_v);
                prod_q   <= P_W'(q2) * P_W'(sin_v);
                out_rf   <= out_next;
                fill     <= fill_next;
            end
        end
    end

endmodule

// File: tb/tb_qam_upconverter.sv
// tb_qam_upconverter: random and directed stimulus against a math-level
// model (ideal sampled carrier, 4-deep delay line) of the upconverter.
module tb_qam_upconverter;

    localparam real PI = 3.14159265358979323846;
    localparam logic [63:0] I_MAX = 64'h007F_FF00_0000_0000;
    localparam logic [63:0] Q_NEG = 64'hFF80_0100_0000_0000;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               clk_enable = 1'b0;
    logic [31:0]        fcw = '0;
    logic               fcw_load = 1'b0;
    logic signed [63:0] in_i = '0;
    logic signed [63:0] in_q = '0;
    logic signed [17:0] out_rf;
    logic               out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_phase;
    logic [31:0] m_fcw;
    longint      m_out;
    bit          m_valid;
    int          m_fill;
    longint      dline[$];

    qam_upconverter dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .fcw        (fcw),
        .fcw_load   (fcw_load),
        .in_i       (in_i),
        .in_q       (in_q),
        .out_rf     (out_rf),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit near(input longint x, input longint t);
        return (x - t <= 2) && (t - x <= 2);
    endfunction

    function automatic longint slice(input logic [63:0] x);
        longint v;
        v = longint'(signed'(x)) >>> 40;
        if (v > 32767)  v = 32767;
        if (v < -32767) v = -32767;
        return v;
    endfunction

    // Carrier sampled at the centre of each of the 1024 phase bins.
    function automatic longint carrier(input logic [31:0] p);
        real    v;
        real    a;
        longint m;
        v = 32767.0 * $sin(2.0 * PI * (real'(p[31:22]) + 0.5) / 1024.0);
        a = (v < 0.0) ? -v : v;
        m = longint'($rtoi(a + 0.5));
        return (v < 0.0) ? -m : m;
    endfunction

    function automatic longint sample(input logic [63:0] a,
                                      input logic [63:0] b,
                                      input logic [31:0] p);
        longint d;
        longint o;
        d = slice(a) * carrier(p + 32'h4000_0000) - slice(b) * carrier(p);
        o = (d + 16384) >>> 15;
        if (o > 131071)  o = 131071;
        if (o < -131071) o = -131071;
        return o;
    endfunction

    task automatic model_reset();
        m_phase = '0;
        m_fcw   = '0;
        m_out   = 0;
        m_valid = 1'b0;
        m_fill  = 0;
        dline   = {0, 0, 0};
    endtask

    task automatic cycle(input logic en, input logic ld,
                         input logic [31:0] f,
                         input logic [63:0] a, input logic [63:0] b);
        clk_enable = en;
        fcw_load   = ld;
        fcw        = f;
        in_i       = a;
        in_q       = b;
        @(posedge clk);
        if (en) begin
            dline.push_back(sample(a, b, m_phase));
            m_out   = dline.pop_front();
            m_phase = m_phase + m_fcw;
            if (ld) m_fcw = f;
            if (m_fill < 4) m_fill++;
        end
        m_valid = en && (m_fill == 4);
        #1;
        check("out_rf", out_rf, m_out);
        check("out_valid", longint'(out_valid), longint'(m_valid));
        check("phase", longint'(dut.phase), longint'(m_phase));
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_out", out_rf, 0);
        check("rst_valid", longint'(out_valid), 0);
        check("rst_phase", longint'(dut.phase), 0);
        #2 reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [63:0] rnd_in();
        logic [63:0]        v;
        logic signed [15:0] s;
        v = {$urandom, $urandom};
        s = 16'($urandom);
        case ($urandom_range(0, 3))
            0:       return v;
            2:       return {8'hFF, 16'h8000, v[39:0]};
            default: return {{8{s[15]}}, s, v[39:0]};
        endcase
    endfunction

    initial begin
        longint d;
        longint held;
        longint p0;

        @(posedge clk);
        #1;
        do_reset();

        // Quarter-turn carrier with full-scale I.
        cycle(1, 1, 32'h4000_0000, I_MAX, '0);
        for (int k = 0; k < 16; k++) begin
            cycle(1, 0, '0, I_MAX, '0);
            if (out_valid) begin
                d = 0;
                if (near(out_rf, 32766) || near(out_rf, -101) ||
                    near(out_rf, -32766) || near(out_rf, 101))
                    d = 1;
                check("t2_pattern", d, 1);
            end
        end

        // Clip of out-of-range inputs at phase 0.
        do_reset();
        for (int k = 0; k < 5; k++)
            cycle(1, 0, '0, 64'h4000_0000_0000_0000, '0);
        check("t3_pos", longint'(near(out_rf, 32766)), 1);
        for (int k = 0; k < 4; k++)
            cycle(1, 0, '0, 64'h8000_0000_0000_0000, '0);
        check("t3_neg", longint'(near(out_rf, -32766)), 1);

        // Q-only at phase 0 sees the half-bin sine offset.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(1, 0, '0, '0, Q_NEG);
            if (k >= 3)
                check("t6_const", longint'(near(out_rf, 101)), 1);
        end

        // Frequency change keeps phase continuous.
        do_reset();
        cycle(1, 1, 32'h4000_0000, rnd_in(), rnd_in());
        for (int k = 0; k < 3; k++)
            cycle(1, 0, '0, rnd_in(), rnd_in());
        p0 = longint'(dut.phase);
        cycle(1, 1, 32'h2000_0000, rnd_in(), rnd_in());
        check("t5_load_step", (longint'(dut.phase) - p0) & 64'hFFFF_FFFF,
              longint'(32'h4000_0000));
        p0 = longint'(dut.phase);
        cycle(1, 0, '0, rnd_in(), rnd_in());
        check("t5_new_step", (longint'(dut.phase) - p0) & 64'hFFFF_FFFF,
              longint'(32'h2000_0000));

        // Reset mid-stream, then refill.
        do_reset();
        cycle(1, 1, $urandom, rnd_in(), rnd_in());
        for (int k = 0; k < 19; k++)
            cycle(1, 0, '0, rnd_in(), rnd_in());
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            cycle(1, 0, '0, rnd_in(), rnd_in());
            check("t1_valid", longint'(out_valid), longint'(k >= 4));
        end

        // Random run with enable gaps and a 10-cycle hold.
        cycle(1, 1, $urandom, rnd_in(), rnd_in());
        for (int k = 0; k < 300; k++) begin
            if (k == 150) begin
                held = out_rf;
                for (int j = 0; j < 10; j++) begin
                    cycle(0, 1, $urandom, rnd_in(), rnd_in());
                    check("t4_hold", out_rf, held);
                    check("t4_valid", longint'(out_valid), 0);
                end
            end
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                  $urandom, rnd_in(), rnd_in());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
